// File: rtl/aes256_ingress_packer.sv
// Ingress packer: assembles narrow beats into 256-bit keys and tagged 128-bit blocks, buffered in a show-ahead FIFO.
// Optional feature macro: AES_INGRESS_ERRCNT_EN adds a saturating err_cnt output.
module aes256_ingress_packer #(
   parameter int IN_W  = 32,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         resetn,
   input  logic [IN_W-1:0]              inp_device,
   input  logic                         ctrl_dataIn,
   input  logic [1:0]                   mod_en,
   output logic                         in_ready,
   output logic [255:0]                 key_out,
   output logic                         key_valid,
   output logic                         key_load,
   output logic [127:0]                 blk_out,
   output logic                         blk_dec,
   output logic                         blk_valid,
   input  logic                         blk_ready,
   output logic                         err_drop,
`ifdef AES_INGRESS_ERRCNT_EN
   output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
   output logic [7:0]                   err_cnt
`else
   output logic [$clog2(DEPTH+1)-1:0]   fifo_level
`endif
);

   localparam int BPB   = 128 / IN_W;
   localparam int KB    = 2 * BPB;
   localparam int CNT_W = $clog2(KB);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'(BPB - 1);
   localparam logic [CNT_W-1:0] KEY_LAST = CNT_W'(KB - 1);
   localparam logic [LVL_W-1:0] FULL     = LVL_W'(DEPTH);
   localparam logic [1:0]       CMD_KEY  = 2'b10;
   localparam logic [1:0]       CMD_RSV  = 2'b11;

   typedef enum logic [1:0] {IDLE, KEY_ASM, DATA_ASM} state_t;

   state_t                       state, state_next;
   logic [CNT_W-1:0]             cnt, cnt_next, pos;
   logic                         mode_dec, mode_next;
   logic [KB-1:0][IN_W-1:0]      key_buf, key_merge;
   logic [BPB-1:0][IN_W-1:0]     blk_buf, blk_merge;
   logic                         accept, push, pop, key_done, key_start, drop;
   logic [PTR_W-1:0]             wr_ptr, rd_ptr;
   logic [128:0]                 mem [DEPTH];
   logic [128:0]                 head;

   // A key beat is held off until every queued block has been consumed under the old key.
   assign in_ready = (fifo_level != FULL) &&
                     !(ctrl_dataIn && (mod_en == CMD_KEY) && (fifo_level != '0));
   assign accept   = ctrl_dataIn & in_ready;
   assign pop      = blk_valid & blk_ready;

   // NOTE: every signal gets a default before any branch, otherwise a latch is inferred.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      mode_next  = mode_dec;
      pos        = cnt;
      push       = 1'b0;
      key_done   = 1'b0;
      key_start  = 1'b0;
      drop       = 1'b0;
      key_merge  = key_buf;
      blk_merge  = blk_buf;
      if (accept) begin
         unique case (mod_en)
            CMD_RSV: begin
               drop       = 1'b1;
               state_next = IDLE;
               cnt_next   = '0;
            end
            CMD_KEY: begin
               if (state != KEY_ASM) begin
                  pos       = '0;
                  key_start = 1'b1;
                  drop      = (state == DATA_ASM);
               end
               for (int i = 0; i < KB; i++)
                  if (pos == CNT_W'(i)) key_merge[i] = inp_device;
               if (pos == KEY_LAST) begin
                  key_done   = 1'b1;
                  state_next = IDLE;
                  cnt_next   = '0;
               end else begin
                  state_next = KEY_ASM;
                  cnt_next   = pos + CNT_W'(1);
               end
            end
            default: begin
               // Data beats mid-key or without a usable key are discarded outright.
               if ((state == KEY_ASM) || !key_valid) begin
                  drop       = 1'b1;
                  state_next = IDLE;
                  cnt_next   = '0;
               end else begin
                  if ((state != DATA_ASM) || (mode_dec != mod_en[0])) begin
                     pos  = '0;
                     drop = (state == DATA_ASM);
                  end
                  mode_next = mod_en[0];
                  for (int i = 0; i < BPB; i++)
                     if (pos == CNT_W'(i)) blk_merge[i] = inp_device;
                  if (pos == BLK_LAST) begin
                     push       = 1'b1;
                     state_next = IDLE;
                     cnt_next   = '0;
                  end else begin
                     state_next = DATA_ASM;
                     cnt_next   = pos + CNT_W'(1);
                  end
               end
            end
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= IDLE;
         cnt        <= '0;
         mode_dec   <= 1'b0;
         key_buf    <= '0;
         blk_buf    <= '0;
         key_out    <= '0;
         key_valid  <= 1'b0;
         key_load   <= 1'b0;
         err_drop   <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
      end else begin
         state    <= state_next;
         cnt      <= cnt_next;
         mode_dec <= mode_next;
         key_buf  <= key_merge;
         blk_buf  <= blk_merge;
         err_drop <= drop;
         key_load <= key_done;
         if (key_done) begin
            key_out   <= key_merge;
            key_valid <= 1'b1;
         end else if (key_start) begin
            key_valid <= 1'b0;
         end
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   fifo_level <= fifo_level + LVL_W'(1);
            2'b01:   fifo_level <= fifo_level - LVL_W'(1);
            default: fifo_level <= fifo_level;
         endcase
      end
   end

   // NOTE: FIFO storage has no reset; the level gates every read so stale entries never escape.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {mode_next, blk_merge};
   end

   assign head      = mem[rd_ptr];
   assign blk_valid = (fifo_level != '0);
   assign blk_out   = blk_valid ? head[127:0] : '0;
   assign blk_dec   = blk_valid & head[128];

`ifdef AES_INGRESS_ERRCNT_EN
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)                            err_cnt <= '0;
      else if (err_drop && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
   end
`endif

endmodule

// File: tb/tb_aes256_ingress_packer.sv
// Directed bench for aes256_ingress_packer (IN_W=32, DEPTH=4): vector table plus hand-written corner sequences.
module tb_aes256_ingress_packer;

   localparam logic [1:0] ENC = 2'b00, DEC = 2'b01, KEY = 2'b10, RSV = 2'b11;

   logic         clk = 1'b0;
   logic         resetn;
   logic [31:0]  inp_device;
   logic         ctrl_dataIn;
   logic [1:0]   mod_en;
   logic         in_ready;
   logic [255:0] key_out;
   logic         key_valid, key_load;
   logic [127:0] blk_out;
   logic         blk_dec, blk_valid, blk_ready, err_drop;
   logic [2:0]   fifo_level;
`ifdef AES_INGRESS_ERRCNT_EN
   logic [7:0]   err_cnt;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   aes256_ingress_packer #(.IN_W(32), .DEPTH(4)) dut (
      .clk(clk), .resetn(resetn), .inp_device(inp_device), .ctrl_dataIn(ctrl_dataIn),
      .mod_en(mod_en), .in_ready(in_ready), .key_out(key_out), .key_valid(key_valid),
      .key_load(key_load), .blk_out(blk_out), .blk_dec(blk_dec), .blk_valid(blk_valid),
      .blk_ready(blk_ready), .err_drop(err_drop), .fifo_level(fifo_level)
`ifdef AES_INGRESS_ERRCNT_EN
      , .err_cnt(err_cnt)
`endif
   );

   typedef struct {
      logic [1:0]  cmd;
      logic [31:0] data;
      logic        err;
      logic        kv;
      logic        kl;
      int          lvl;
   } vec_t;

   vec_t tbl[$];

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic [1:0] cmd, input logic [31:0] data, input logic err,
                      input logic kv, input logic kl, input int lvl);
      vec_t v;
      v.cmd = cmd; v.data = data; v.err = err; v.kv = kv; v.kl = kl; v.lvl = lvl;
      tbl.push_back(v);
   endtask

   // Presents one beat and returns just after the edge that accepts it.
   task automatic send(input logic [1:0] cmd, input logic [31:0] d);
      int n;
      n = 0;
      ctrl_dataIn = 1'b1;
      mod_en      = cmd;
      inp_device  = d;
      #1;
      while (!in_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) check("send_timeout", 0, 1);
      @(posedge clk); #1;
      ctrl_dataIn = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   function automatic logic [127:0] mk_blk(input int b);
      logic [127:0] r;
      for (int k = 0; k < 4; k++) r[k*32 +: 32] = 32'(b * 256 + k);
      return r;
   endfunction

   logic [255:0] exp_key;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 32; i++) exp_key[i*8 +: 8] = 8'(i);

      // Errors with no key, key load, encrypt block, mode change, reserved command.
      for (int k = 1; k <= 4; k++) add(ENC, 32'(k), 1, 0, 0, 0);
      for (int k = 0; k < 8; k++)
         add(KEY, 32'h03020100 + 32'(k) * 32'h04040404, 0, k == 7, k == 7, 0);
      add(ENC, 32'd1, 0, 1, 0, 0);
      add(ENC, 32'd2, 0, 1, 0, 0);
      add(ENC, 32'd3, 0, 1, 0, 0);
      add(ENC, 32'd4, 0, 1, 0, 1);
      add(ENC, 32'd5, 0, 1, 0, 1);
      add(ENC, 32'd6, 0, 1, 0, 1);
      add(DEC, 32'd7, 1, 1, 0, 1);
      add(DEC, 32'd8, 0, 1, 0, 1);
      add(DEC, 32'd9, 0, 1, 0, 1);
      add(DEC, 32'd10, 0, 1, 0, 2);
      add(RSV, 32'hDEAD, 1, 1, 0, 2);

      resetn = 1'b0; ctrl_dataIn = 1'b0; mod_en = ENC; inp_device = '0; blk_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", in_ready, 1);
      check("rst_key_out", key_out, 0);
      check("rst_key_valid", key_valid, 0);
      check("rst_key_load", key_load, 0);
      check("rst_blk_out", blk_out, 0);
      check("rst_blk_dec", blk_dec, 0);
      check("rst_blk_valid", blk_valid, 0);
      check("rst_err_drop", err_drop, 0);
      check("rst_level", fifo_level, 0);
      resetn = 1'b1;
      tick();
      check("rel_in_ready", in_ready, 1);
      check("rel_key_valid", key_valid, 0);
      check("rel_blk_valid", blk_valid, 0);
      check("rel_level", fifo_level, 0);

      foreach (tbl[i]) begin
         send(tbl[i].cmd, tbl[i].data);
         check($sformatf("v%0d_err_drop", i), err_drop, tbl[i].err);
         check($sformatf("v%0d_key_valid", i), key_valid, tbl[i].kv);
         check($sformatf("v%0d_key_load", i), key_load, tbl[i].kl);
         check($sformatf("v%0d_level", i), fifo_level, tbl[i].lvl);
         check($sformatf("v%0d_blk_valid", i), blk_valid, tbl[i].lvl != 0);
      end
      check("key_out", key_out, exp_key);
      check("enc_blk", blk_out, 128'h00000004000000030000000200000001);
      check("enc_dec", blk_dec, 0);

      blk_ready = 1'b1; tick(); blk_ready = 1'b0;
      check("pop1_level", fifo_level, 1);
      check("dec_blk", blk_out, {32'd10, 32'd9, 32'd8, 32'd7});
      check("dec_tag", blk_dec, 1);
`ifdef AES_INGRESS_ERRCNT_EN
      check("err_cnt", err_cnt, 6);
`endif
      blk_ready = 1'b1; tick();
      check("pop2_level", fifo_level, 0);
      check("empty_blk_out", blk_out, 0);
      check("empty_valid", blk_valid, 0);
      tick(); blk_ready = 1'b0;
      check("pop_empty_level", fifo_level, 0);

      // Backpressure: fill with four decrypt blocks, stall the fifth.
      for (int b = 1; b <= 4; b++)
         for (int k = 0; k < 4; k++) send(DEC, 32'(b * 256 + k));
      check("full_level", fifo_level, 4);
      ctrl_dataIn = 1'b1; mod_en = DEC; inp_device = 32'(5 * 256);
      #1;
      check("full_in_ready", in_ready, 0);
      tick();
      check("stall_in_ready", in_ready, 0);
      check("stall_level", fifo_level, 4);
      check("stall_head", blk_out, mk_blk(1));
      blk_ready = 1'b1;
      #1;
      check("full_pop_in_ready", in_ready, 0);
      @(posedge clk); #1;
      blk_ready = 1'b0;
      check("after_pop_level", fifo_level, 3);
      check("after_pop_in_ready", in_ready, 1);
      check("after_pop_head", blk_out, mk_blk(2));
      for (int k = 0; k < 4; k++) send(DEC, 32'(5 * 256 + k));
      check("refill_level", fifo_level, 4);

      // Drain in order while a key beat waits for the FIFO to empty.
      ctrl_dataIn = 1'b1; mod_en = KEY; inp_device = 32'hA5A5A5A5;
      blk_ready = 1'b1;
      for (int b = 2; b <= 5; b++) begin
         #1;
         check($sformatf("drain%0d_head", b), blk_out, mk_blk(b));
         check($sformatf("drain%0d_dec", b), blk_dec, 1);
         check($sformatf("drain%0d_key_stall", b), in_ready, 0);
         @(posedge clk); #1;
      end
      blk_ready = 1'b0;
      check("drained_level", fifo_level, 0);
      check("drained_in_ready", in_ready, 1);
      check("drained_key_valid", key_valid, 1);
      tick();
      ctrl_dataIn = 1'b0;
      check("key_start_clears_valid", key_valid, 0);
      send(KEY, 32'hB6B6B6B6);

      // Reset two beats into a key.
      resetn = 1'b0;
      #1;
      check("rst_key_mid_valid", key_valid, 0);
      check("rst_key_mid_out", key_out, 0);
`ifdef AES_INGRESS_ERRCNT_EN
      check("rst_err_cnt", err_cnt, 0);
`endif
      tick();
      resetn = 1'b1;

      // Reset with two blocks queued and a partial block pending.
      for (int k = 0; k < 8; k++) send(KEY, 32'h03020100 + 32'(k) * 32'h04040404);
      check("reload_key_load", key_load, 1);
      check("reload_key_out", key_out, exp_key);
      for (int b = 6; b <= 7; b++)
         for (int k = 0; k < 4; k++) send(ENC, 32'(b * 256 + k));
      send(ENC, 32'h11);
      send(ENC, 32'h22);
      check("pre_rst_level", fifo_level, 2);
      check("pre_rst_head", blk_out, mk_blk(6));
      #2;
      resetn = 1'b0;
      #1;
      check("mid_rst_blk_valid", blk_valid, 0);
      check("mid_rst_key_valid", key_valid, 0);
      check("mid_rst_level", fifo_level, 0);
      check("mid_rst_blk_out", blk_out, 0);
      tick();
      resetn = 1'b1;
      send(ENC, 32'h33);
      check("post_rst_drop", err_drop, 1);
      check("post_rst_level", fifo_level, 0);
      tick();
      check("err_drop_one_cycle", err_drop, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/aes256_ingress_packer.md
# aes256_ingress_packer

Parametrised ingress front-end for the AES256 device. Accepts narrow command/data beats on the `ctrl_dataIn`/`mod_en`/`inp_device` input convention, assembles 256-bit keys and 128-bit blocks, and buffers tagged blocks in a FIFO. Presents blocks to the cipher core over a valid/ready handshake. It generalises the fixed 128-bit single-block input path to configurable bus width and buffer depth, and adds backpressure and protocol-error handling.

## Interface
- `IN_W`, 32, beat width; legal values 32, 64, 128.
- `DEPTH`, 4, block FIFO entries; power of 2, ≥2.
- `clk` in 1: single clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `inp_device` in IN_W: beat payload.
- `ctrl_dataIn` in 1: beat valid.
- `mod_en` in 2: beat command; 2'b10 key, 2'b00 encrypt, 2'b01 decrypt, 2'b11 reserved.
- `in_ready` out 1: beat accepted when `ctrl_dataIn & in_ready` at the clock edge.
- `key_out` out 256: assembled key.
- `key_valid` out 1: `key_out` complete and usable.
- `key_load` out 1: one-cycle pulse when a new key completes.
- `blk_out` out 128: FIFO head block.
- `blk_dec` out 1: head tag; 1 means decrypt.
- `blk_valid` out 1: FIFO non-empty.
- `blk_ready` in 1: core pops the head when `blk_valid & blk_ready`.
- `err_drop` out 1: one-cycle pulse per dropped beat or discarded partial.
- `fifo_level` out $clog2(DEPTH+1): current occupancy.

## Operation
- Derived constants:
  - BPB = 128/IN_W beats per block.
  - KB = 2·BPB beats per key.
- Packing is little-endian. Beat k occupies bits [k·IN_W +: IN_W] of the block or key.
- FSM states: IDLE, KEY_ASM, DATA_ASM. A beat counter tracks the position within the current unit.
- IDLE:
  - Accepted key beat → KEY_ASM. `key_valid` clears on the same edge.
  - Accepted enc/dec beat → DATA_ASM. The mode is latched.
- KEY_ASM: after beat KB-1 → IDLE. `key_out` is updated, `key_valid`=1, `key_load` pulses.
- DATA_ASM: after beat BPB-1 the block and tag are pushed to the FIFO → IDLE.
- Command change mid-unit (the beat's `mod_en` differs from the latched mode):
  - The partial unit is discarded and `err_drop` pulses.
  - The new beat starts a fresh unit as if issued from IDLE.
  - An interrupted key leaves `key_valid`=0.
- An enc/dec beat while `key_valid`=0 is dropped, `err_drop` pulses, and the state is unchanged.
- A `mod_en`=2'b11 beat is dropped, `err_drop` pulses, and any partial unit is discarded.
- `in_ready` is 0 when either condition holds:
  - `fifo_level`==DEPTH.
  - `ctrl_dataIn & mod_en==2'b10` while `fifo_level`≠0 (a key change waits for the FIFO to drain).
- Otherwise `in_ready` is 1. It is combinational from state, level and the current inputs.
- FIFO:
  - Show-ahead, ordered.
  - Push and pop on the same edge leave the level unchanged.
  - Pop when empty is ignored.

## Timing
- Reset values:
  - `in_ready`=1 (no beat pending).
  - `key_out`=0, `key_valid`=0, `key_load`=0.
  - `blk_out`=0, `blk_dec`=0, `blk_valid`=0.
  - `err_drop`=0, `fifo_level`=0.
  - FSM in IDLE, beat counter 0, FIFO pointers 0.
- Final data beat accepted at edge N → `blk_valid`=1 and data on `blk_out` from just after edge N. Zero added latency.
- Final key beat at edge N → `key_valid` and `key_load` high after N. `key_load` low after N+1.
- `err_drop` is registered: high for the one cycle after the offending edge.
- Full FIFO with a pop in the same cycle: `in_ready` stays 0 that cycle; a push is possible the next cycle.
- Reset asserted mid-assembly or with the FIFO non-empty: all state clears immediately. Partial units and buffered blocks are lost.

## Configuration
- `AES_INGRESS_ERRCNT_EN` defined: adds output `err_cnt` [7:0]. It increments on every `err_drop` pulse, saturates at 255, and resets to 0.
- Undefined: the `err_cnt` port and counter are absent. `err_drop` behaviour is identical.

## Test plan
All scenarios use IN_W=32, DEPTH=4.
- Reset: hold `resetn`=0 → all outputs at the reset values above, `in_ready`=1. Release → no output change.
- Key: 8 key beats 32'h03020100, 32'h07060504, …, 32'h1f1e1d1c → `key_out`=256'h1f1e…0100. `key_valid`=1 and a single `key_load` pulse after beat 8.
- Encrypt: 4 enc beats 32'h1, 32'h2, 32'h3, 32'h4 → `blk_out`=128'h00000004000000030000000200000001, `blk_dec`=0, `blk_valid` high the cycle after beat 4.
- Backpressure: `blk_ready`=0, push 5 decrypt blocks → `fifo_level`=4 and `in_ready`=0 on the 5th block's first beat. Then `blk_ready`=1 → 5 blocks popped in order with `blk_dec`=1. A key beat is stalled until the level reaches 0.
- Errors:
  - 4 enc beats after reset → 4 `err_drop` pulses, level 0, `err_cnt`=4 if `AES_INGRESS_ERRCNT_EN` is defined.
  - 2 enc beats then a dec beat → 1 `err_drop` pulse; the dec block completes 3 beats later.
- Reset mid-op: FIFO at 2 and 2 beats into a key → assert `resetn` → `blk_valid`=0, `key_valid`=0, `fifo_level`=0 immediately.
